// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions: FSM state encoding and default
//                frame width / SCLK divider used by master and slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default frame width in bits
    localparam int c_SPI_DATA_W  = 4;
    // Default SCLK half-period in system clock cycles
    localparam int c_SPI_CLK_DIV = 2;
    // Phase timer width, wide enough for a divider of 255
    localparam int c_TIMER_W     = 8;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_timer
//  Description : Counts CLK_DIV system clock cycles per SPI phase and flags
//                the last cycle of each phase with phase_end.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = c_SPI_CLK_DIV
) (
    input  logic FPGA_clk,
    input  logic FPGA_reset,
    input  logic clear,
    output logic phase_end
);

    localparam logic [c_TIMER_W-1:0] c_LAST = c_TIMER_W'(CLK_DIV - 1);

    logic [c_TIMER_W-1:0] r_cnt;

    // Phase counter: restarts on clear or at the end of every phase
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            r_cnt <= '0;
        end else if (clear || phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign phase_end = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_tx
//  Description : SPI mode-0 master. Sends one DATA_W-bit word MSB first and
//                captures the word returned on MISO; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W  = c_SPI_DATA_W,
    parameter int CLK_DIV = c_SPI_CLK_DIV
) (
    input  logic              FPGA_clk,
    input  logic              FPGA_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_ss_n,
    input  logic              spi_miso
);

    localparam int                 c_BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

    spi_state_t          r_state;
    spi_state_t          w_state_next;

    logic                r_ss_n;
    logic                r_sclk;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_rx_data;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [c_BIT_W-1:0]  r_bit_cnt;

    logic                w_ss_n;
    logic                w_sclk;
    logic                w_busy;
    logic                w_done;
    logic [DATA_W-1:0]   w_rx_data;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_shift;
    logic [c_BIT_W-1:0]  w_bit_cnt;

    logic                w_phase_end;
    logic                w_timer_clear;

    // The timer is held at zero while idle so LEAD always gets a full phase
    assign w_timer_clear = (r_state == IDLE);

    spi_edge_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_edge_timer (
        .FPGA_clk   (FPGA_clk),
        .FPGA_reset (FPGA_reset),
        .clear      (w_timer_clear),
        .phase_end  (w_phase_end)
    );

    // State register
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode; every output change is applied on
    // the same edge as the state transition that causes it
    always_comb begin
        w_state_next = r_state;
        w_ss_n       = r_ss_n;
        w_sclk       = r_sclk;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_rx_data    = r_rx_data;
        w_tx_shift   = r_tx_shift;
        w_rx_shift   = r_rx_shift;
        w_bit_cnt    = r_bit_cnt;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LEAD;
                    w_tx_shift   = tx_data;
                    w_rx_shift   = '0;
                    w_bit_cnt    = '0;
                    w_ss_n       = 1'b0;
                    w_busy       = 1'b1;
                end
            end
            LEAD: begin
                if (w_phase_end) begin
                    w_state_next = HIGH;
                    w_sclk       = 1'b1;
                end
            end
            HIGH: begin
                if (w_phase_end) begin
                    w_state_next = LOW;
                    w_sclk       = 1'b0;
                    w_rx_shift   = {r_rx_shift[DATA_W-2:0], spi_miso};
                    // Last bit stays on MOSI through TRAIL
                    if (r_bit_cnt != c_LAST_BIT) begin
                        w_tx_shift = {r_tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            LOW: begin
                if (w_phase_end) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_next = TRAIL;
                    end else begin
                        w_state_next = HIGH;
                        w_sclk       = 1'b1;
                        w_bit_cnt    = r_bit_cnt + c_BIT_W'(1);
                    end
                end
            end
            TRAIL: begin
                if (w_phase_end) begin
                    w_state_next = GAP;
                    w_ss_n       = 1'b1;
                end
            end
            GAP: begin
                if (w_phase_end) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                    w_busy       = 1'b0;
                    w_rx_data    = r_rx_shift;
                    w_tx_shift   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            r_ss_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_data  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_ss_n     <= w_ss_n;
            r_sclk     <= w_sclk;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_rx_data  <= w_rx_data;
            r_tx_shift <= w_tx_shift;
            r_rx_shift <= w_rx_shift;
            r_bit_cnt  <= w_bit_cnt;
        end
    end

    assign spi_ss_n = r_ss_n;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_tx_shift[DATA_W-1];
    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_data  = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_tx
//  Description : Self-checking bench for spi_master_tx. Three instances:
//                index 0 with CLK_DIV=2, index 1 with CLK_DIV=1, index 2 with
//                CLK_DIV=3, each with its own mode-0 slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_tx;

    localparam int W = 4;

    logic FPGA_clk   = 1'b0;
    logic FPGA_reset = 1'b1;
    always #5 FPGA_clk = ~FPGA_clk;

    logic [2:0]         start      = '0;
    logic [2:0][W-1:0]  tx_data    = '0;
    logic [2:0][W-1:0]  slave_word = '0;
    logic [2:0]         loopback   = '0;

    wire  [2:0]         busy;
    wire  [2:0]         done;
    wire  [2:0]         sclk;
    wire  [2:0]         mosi;
    wire  [2:0]         ss_n;
    wire  [2:0]         miso;
    wire  [2:0][W-1:0]  rx_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] rx;
        logic [W-1:0] srx;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] sw;
        logic         lb;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_srx;
    } vec_t;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

        logic         sclk_prev = 1'b0;
        logic         ss_prev   = 1'b1;
        logic [3:0]   fall_cnt  = '0;
        logic [3:0]   rise_cnt  = '0;
        logic [W-1:0] slave_rx  = '0;
        int           done_cnt  = 0;
        int           sclk_bad  = 0;
        wire  [W-1:0] sw_shifted;

        spi_master_tx #(
            .DATA_W  (W),
            .CLK_DIV (DIV)
        ) u_dut (
            .FPGA_clk   (FPGA_clk),
            .FPGA_reset (FPGA_reset),
            .start      (start[g]),
            .tx_data    (tx_data[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .rx_data    (rx_data[g]),
            .spi_sclk   (sclk[g]),
            .spi_mosi   (mosi[g]),
            .spi_ss_n   (ss_n[g]),
            .spi_miso   (miso[g])
        );

        // Mode-0 slave: presents its MSB when selected, moves to the next bit
        // after each falling SCLK, samples MOSI on rising SCLK
        assign sw_shifted = slave_word[g] << fall_cnt;
        assign miso[g]    = loopback[g] ? mosi[g] : sw_shifted[W-1];

        always @(posedge FPGA_clk) begin
            #1;
            if (ss_prev && !ss_n[g]) begin
                fall_cnt = '0;
                rise_cnt = '0;
                slave_rx = '0;
            end
            if (!sclk_prev && sclk[g]) begin
                rise_cnt = rise_cnt + 4'd1;
                slave_rx = {slave_rx[W-2:0], mosi[g]};
                if (ss_n[g]) sclk_bad++;
            end
            if (sclk_prev && !sclk[g]) fall_cnt = fall_cnt + 4'd1;
            if (done[g]) done_cnt++;
            sclk_prev = sclk[g];
            ss_prev   = ss_n[g];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One CLK_DIV=2 frame on instance 0; expectation goes to the scoreboard
    // at drive time and is popped when done appears. Extra start pulses are
    // applied at relative cycles pa/pb (0 = none).
    task automatic frame_a(input vec_t v, input int pa, input int pb);
        exp_t e;
        int   ss_rise;
        int   done_at;
        logic busy_ok;
        int   d0;
        @(negedge FPGA_clk);
        tx_data[0]    = v.tx;
        slave_word[0] = v.sw;
        loopback[0]   = v.lb;
        start[0]      = 1'b1;
        e.rx  = v.exp_rx;
        e.srx = v.exp_srx;
        sb_q.push_back(e);
        d0 = g_dut[0].done_cnt;
        @(negedge FPGA_clk);
        start[0] = 1'b0;
        check("accept_ss_n_low", ss_n[0], 0);
        check("accept_busy", busy[0], 1);
        check("accept_mosi_msb", mosi[0], v.tx[W-1]);
        ss_rise = -1;
        done_at = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            start[0] = (k == pa) || (k == pb);
            @(negedge FPGA_clk);
            if (ss_rise < 0 && ss_n[0]) ss_rise = k;
            if (done[0]) begin
                done_at = k;
                if (sb_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("rx_data", rx_data[0], e.rx);
                    check("slave_rx", g_dut[0].slave_rx, e.srx);
                    check("sclk_rises", g_dut[0].rise_cnt, W);
                end
            end else if (!busy[0]) begin
                busy_ok = 1'b0;
            end
        end
        start[0] = 1'b0;
        // ss_n rises at (2*W+2)*CLK_DIV = 20, done one GAP later at 22
        check("ss_n_rise_edge", ss_rise, 20);
        check("done_edge", done_at, 22);
        check("busy_until_done", busy_ok, 1);
        check("busy_low_on_done", busy[0], 0);
        repeat (30) @(negedge FPGA_clk);
        check("single_done", g_dut[0].done_cnt - d0, 1);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v36;
        int   bad;
        int   d0;
        int   done_at;
        int   nd;
        int   done_k[3];
        int   ss_run;
        int   min_run;
        logic seen_low;

        //           tx        slave     loop  exp_rx    exp_slave_rx
        vecs[0] = '{4'b1010, 4'b0000, 1'b1, 4'b1010, 4'b1010};
        vecs[1] = '{4'b0101, 4'b0000, 1'b1, 4'b0101, 4'b0101};
        vecs[2] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111};
        vecs[3] = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000};
        vecs[4] = '{4'b1001, 4'b0110, 1'b0, 4'b0110, 4'b1001};
        vecs[5] = '{4'b1100, 4'b0011, 1'b0, 4'b0011, 4'b1100};
        vecs[6] = '{4'b0001, 4'b1000, 1'b0, 4'b1000, 4'b0001};
        v36     = '{4'b0110, 4'b0000, 1'b1, 4'b0110, 4'b0110};

        // Reset state of all instances
        repeat (3) @(negedge FPGA_clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_ctrl_outputs", {ss_n[g], sclk[g], mosi[g], busy[g], done[g]}, 5'b10000);
            check("reset_rx_data", rx_data[g], 0);
        end
        FPGA_reset = 1'b0;

        // No start: lines stay idle
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge FPGA_clk);
            if (ss_n != 3'b111 || sclk != 3'b000 || mosi != 3'b000 || busy != 3'b000) bad++;
        end
        check("idle_1000_cycles", bad, 0);

        // Reset nine cycles into a CLK_DIV=2 frame aborts it silently
        @(negedge FPGA_clk);
        tx_data[0]  = 4'b1010;
        loopback[0] = 1'b1;
        start[0]    = 1'b1;
        d0 = g_dut[0].done_cnt;
        @(negedge FPGA_clk);
        start[0] = 1'b0;
        repeat (9) @(negedge FPGA_clk);
        check("mid_frame_busy", busy[0], 1);
        check("mid_frame_ss_n", ss_n[0], 0);
        FPGA_reset = 1'b1;
        #1;
        check("abort_ctrl_outputs", {ss_n[0], sclk[0], mosi[0], busy[0], done[0]}, 5'b10000);
        repeat (2) @(negedge FPGA_clk);
        FPGA_reset = 1'b0;
        repeat (40) @(negedge FPGA_clk);
        check("abort_no_done", g_dut[0].done_cnt - d0, 0);
        check("abort_rx_unchanged", rx_data[0], 0);

        // Vector table; the first frame is also the first start after reset
        for (int i = 0; i < 7; i++) begin
            frame_a(vecs[i], 0, 0);
        end

        // Extra start pulses during an active frame are dropped
        frame_a(v36, 3, 10);

        // CLK_DIV=1: master sends 1111, slave returns 0110
        @(negedge FPGA_clk);
        tx_data[1]    = 4'b1111;
        slave_word[1] = 4'b0110;
        loopback[1]   = 1'b0;
        start[1]      = 1'b1;
        @(negedge FPGA_clk);
        start[1] = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge FPGA_clk);
            if (done[1]) done_at = k;
        end
        check("div1_done_edge", done_at, 11);
        check("div1_sclk_rises", g_dut[1].rise_cnt, 4);
        check("div1_slave_rx", g_dut[1].slave_rx, 4'b1111);
        check("div1_rx_data", rx_data[1], 4'b0110);

        // CLK_DIV=3 with start held: 33-cycle frames, each next frame
        // accepted on the edge after done, so dones are 34 cycles apart
        @(negedge FPGA_clk);
        tx_data[2]  = 4'b1100;
        loopback[2] = 1'b1;
        start[2]    = 1'b1;
        nd       = 0;
        ss_run   = 0;
        min_run  = 1000;
        seen_low = 1'b0;
        done_k   = '{-1, -1, -1};
        for (int k = 1; k <= 200 && nd < 3; k++) begin
            @(negedge FPGA_clk);
            if (!ss_n[2]) begin
                if (seen_low && ss_run > 0 && ss_run < min_run) min_run = ss_run;
                ss_run   = 0;
                seen_low = 1'b1;
            end else if (seen_low) begin
                ss_run++;
            end
            if (done[2]) begin
                done_k[nd] = k;
                nd++;
                if (nd == 3) start[2] = 1'b0;
            end
        end
        start[2] = 1'b0;
        check("div3_three_dones", nd, 3);
        check("div3_spacing_1", done_k[1] - done_k[0], 34);
        check("div3_spacing_2", done_k[2] - done_k[1], 34);
        check("div3_ss_gap_ge3", (min_run >= 3 && min_run < 1000), 1);
        repeat (50) @(negedge FPGA_clk);
        check("div3_done_total", g_dut[2].done_cnt, 3);
        check("div3_idle_after", {ss_n[2], busy[2]}, 2'b10);

        check("no_sclk_while_deselected",
              g_dut[0].sclk_bad + g_dut[1].sclk_bad + g_dut[2].sclk_bad, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
